qmac_accum: RTL and testbench
=============================

# qmac_accum

Sequential accumulator that consumes the sign-magnitude fixed-point products of the `qmult` stage and sums a programmed number of them into a single saturated result in the same format. It sits directly downstream of the multiplier in the dot-product / FIR datapath. It takes one term per accepted handshake and returns the rounded-free, saturated sum with an overflow flag.

## Interface
- `Q`, 15, number of fractional bits (must match upstream multiplier)
- `N`, 32, word width; bit N-1 = sign, bits N-2:0 = magnitude
- `LEN_W`, 8, width of term-count field; max terms = 2^LEN_W-1
- `GUARD`, 8, extra integer bits in the internal accumulator
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin new accumulation; sampled only in IDLE
- `len` in LEN_W: number of terms, latched on `start`
- `in_valid` in 1: `in_data` holds a product
- `in_ready` out 1: block accepts a term this cycle
- `in_data` in N: sign-magnitude Q(N-1-Q).Q product
- `out_valid` out 1: result available
- `out_ready` in 1: downstream accepts result
- `out_data` out N: saturated sign-magnitude sum
- `out_ovf` out 1: sum saturated, qualified by `out_valid`
- `busy` out 1: high in any state except IDLE

## Operation
- States: IDLE, ACC, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. On `start`: latch `len` into count, clear accumulator (N+GUARD bits, two's complement). Next state ACC, or DONE if `len`=0 (result 0, ovf 0).
- ACC: `in_ready`=1. Each cycle with `in_valid`&`in_ready`: convert term to two's complement (sign ? -mag : mag, sign-extended), add to accumulator, decrement count. When the accepted term is the last one (count=1), next state DONE.
- DONE entry: register result. If acc > 2^(N-1)-1, `out_data`={0,all ones}, ovf=1. If acc < -(2^(N-1)-1), `out_data`={1,all ones}, ovf=1. Otherwise `out_data` = sign-magnitude of acc, ovf=0. A zero sum is always emitted as +0 (0x0); -0 inputs are treated as 0.
- DONE: hold `out_valid`=1, `out_data`, and `out_ovf` stable until `out_ready`. Then go to IDLE.
- `start` outside IDLE is ignored. `start` in the same cycle as the DONE→IDLE handoff is ignored; it is accepted the following cycle.
- GUARD overflow of the internal accumulator cannot occur for len ≤ 2^GUARD. This is required as a parameter constraint: LEN_W ≤ GUARD.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `out_ovf`, `busy` = 0; `out_data` = 0; accumulator and count = 0.
- All outputs are registered. `in_ready` and `busy` are decoded from the state register.
- `start` accepted at edge t: `in_ready`=1 from cycle t+1.
- Last term accepted at edge t: `in_ready`=0 and `out_valid`=1 from cycle t+1, i.e. 1-cycle latency.
- With `len`=0, `out_valid` rises one cycle after `start`.
- Throughput is one term per cycle. A full job of L terms takes L+2 cycles minimum to return to IDLE.
- `rst_n` low mid-operation immediately forces the reset values. A partial sum is discarded and no `out_valid` is produced.

## Structure
- `qpoint_pkg`: default Q/N, state enum type (IDLE/ACC/DONE), and functions `sm_to_tc` and `tc_to_sm_sat`. These are shared with future qpoint datapath blocks.
- One sub-module: `qsm_to_tc`, a combinational sign-magnitude to sign-extended two's complement converter, instantiated on the input path.

## Test plan
- len=3; terms 0x00008000, 0x00008000, 0x80004000 (1.0, 1.0, -0.5) -> out_data 0x0000C000, ovf 0, `out_valid` one cycle after the 3rd accept.
- len=3; three terms of 0x7FFFFFFF -> out_data 0x7FFFFFFF, ovf 1. Repeat with 0xFFFFFFFF -> 0xFFFFFFFF, ovf 1.
- len=2; terms 0x00010000, 0x80010000 -> out_data 0x00000000 (not 0x80000000), ovf 0.
- len=0 with `start` -> `out_valid` next cycle, out_data 0, ovf 0. `in_ready` never asserted.
- len=4 with random `in_valid` gaps; hold `out_ready`=0 for 5 cycles and pulse `start` meanwhile -> sum correct, outputs held stable, extra `start` ignored, IDLE after `out_ready`.
- Assert `rst_n`=0 after 2 of 4 terms -> all outputs 0 asynchronously. A new job after reset gives the correct sum with no residue.

Source files
------------

// File: rtl/qpoint_pkg.sv
// rtl/qpoint_pkg.sv - shared fixed-point types and sign-magnitude helpers for qpoint blocks
package qpoint_pkg;

  localparam int Q_DEF     = 15;
  localparam int N_DEF     = 32;
  localparam int GUARD_DEF = 8;
  localparam int ACC_W_DEF = N_DEF + GUARD_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign-magnitude word to sign-extended two's complement; -0 maps to 0.
  function automatic logic [ACC_W_DEF-1:0] sm_to_tc(input logic [N_DEF-1:0] sm);
    logic [ACC_W_DEF-1:0] mag;
    mag = {{(GUARD_DEF+1){1'b0}}, sm[N_DEF-2:0]};
    return sm[N_DEF-1] ? -mag : mag;
  endfunction

  // Two's complement to saturated sign-magnitude; returns {ovf, word}, zero is +0.
  function automatic logic [N_DEF:0] tc_to_sm_sat(input logic [ACC_W_DEF-1:0] acc);
    logic [ACC_W_DEF-1:0] max_pos;
    logic [N_DEF-2:0]     mag;
    max_pos = {{(GUARD_DEF+1){1'b0}}, {(N_DEF-1){1'b1}}};
    if ($signed(acc) > $signed(max_pos)) begin
      return {1'b1, 1'b0, {(N_DEF-1){1'b1}}};
    end else if ($signed(acc) < $signed(-max_pos)) begin
      return {1'b1, 1'b1, {(N_DEF-1){1'b1}}};
    end
    mag = acc[ACC_W_DEF-1] ? -acc[N_DEF-2:0] : acc[N_DEF-2:0];
    return {1'b0, acc[ACC_W_DEF-1], mag};
  endfunction

endpackage

// File: rtl/qsm_to_tc.sv
// rtl/qsm_to_tc.sv - combinational sign-magnitude to sign-extended two's complement
module qsm_to_tc #(
  parameter int N = 32,
  parameter int W = 40
) (
  input  logic [N-1:0] sm,
  output logic [W-1:0] tc
);

  logic [W-1:0] mag;

  // Zero-extend the magnitude, then negate when the sign bit is set (-0 becomes 0).
  always_comb begin
    mag = {{(W-N+1){1'b0}}, sm[N-2:0]};
    tc  = sm[N-1] ? -mag : mag;
  end

endmodule

// File: rtl/qmac_accum.sv
// rtl/qmac_accum.sv - saturating accumulator of sign-magnitude products over a programmed length
module qmac_accum
  import qpoint_pkg::*;
#(
  parameter int Q     = Q_DEF,
  parameter int N     = N_DEF,
  parameter int LEN_W = 8,
  parameter int GUARD = GUARD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovf,
  output logic             busy
);

  // Guard bits absorb growth of up to 2^GUARD full-scale terms, so LEN_W must not exceed GUARD.
  localparam int W = N + GUARD;
  localparam logic [W-1:0] MAX_POS = {{(GUARD+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = -MAX_POS;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] count;
  logic [W-1:0]     acc;
  logic [W-1:0]     term_tc;
  logic [W-1:0]     acc_sum;
  logic             last_term;
  logic [N-1:0]     sat_data;
  logic             sat_ovf;

  qsm_to_tc #(.N(N), .W(W)) u_sm_to_tc (
    .sm (in_data),
    .tc (term_tc)
  );

  assign acc_sum   = acc + term_tc;
  assign last_term = (count == LEN_W'(1));

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Clamp the running sum (including the term being accepted) to the output word.
  always_comb begin
    sat_data = '0;
    sat_ovf  = 1'b0;
    if ($signed(acc_sum) > $signed(MAX_POS)) begin
      sat_data = {1'b0, {(N-1){1'b1}}};
      sat_ovf  = 1'b1;
    end else if ($signed(acc_sum) < $signed(MIN_NEG)) begin
      sat_data = {1'b1, {(N-1){1'b1}}};
      sat_ovf  = 1'b1;
    end else begin
      sat_data = {acc_sum[W-1], (acc_sum[W-1] ? -acc_sum[N-2:0] : acc_sum[N-2:0])};
    end
  end

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (len == '0) ? ST_DONE : ST_ACC;
      ST_ACC:  if (in_valid && last_term) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Count, accumulator and result registers; the result is captured with the last term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count    <= len;
            acc      <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            acc   <= acc_sum;
            count <= count - LEN_W'(1);
            if (last_term) begin
              out_data <= sat_data;
              out_ovf  <= sat_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qmac_accum.sv
// tb/tb_qmac_accum.sv - randomized self-checking bench for qmac_accum
module tb_qmac_accum;

  localparam int Q = 15, N = 32, LEN_W = 8, GUARD = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_data;
  logic             out_ovf;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  qmac_accum #(.Q(Q), .N(N), .LEN_W(LEN_W), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic longint sm_val(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  // Reference: exact integer sum, then clamp to +/-(2^31-1); returns {ovf, word}.
  function automatic logic [32:0] model(input logic [31:0] terms[$]);
    longint s;
    longint maxv;
    logic [30:0] m;
    s = 0;
    maxv = 64'sd2147483647;
    foreach (terms[i]) s += sm_val(terms[i]);
    if (s > maxv)  return {1'b1, 32'h7FFF_FFFF};
    if (s < -maxv) return {1'b1, 32'hFFFF_FFFF};
    if (s < 0) begin
      m = 31'(-s);
      return {1'b0, 1'b1, m};
    end
    m = 31'(s);
    return {1'b0, 1'b0, m};
  endfunction

  function automatic logic [31:0] rand_term();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(1) == 1) r[30:20] = '0;
    return r;
  endfunction

  task automatic begin_job(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] terms[$], input int gap_pct, output bit timed_out);
    int  i;
    int  cyc;
    bit  took;
    i = 0;
    cyc = 0;
    timed_out = 1'b0;
    while (i < terms.size()) begin
      if (cyc >= 2000) begin
        timed_out = 1'b1;
        break;
      end
      in_data  = terms[i];
      in_valid = ($urandom_range(99) >= gap_pct);
      took     = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (took) i++;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
  endtask

  task automatic test_basic();
    logic [31:0] t[$];
    bit to;
    t = '{32'h0000_8000, 32'h0000_8000, 32'h8000_4000};
    begin_job(3);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_start_latency in_ready got %b want 1", in_ready); end
    feed(t, 0, to);
    n_tests++; if (to !== 1'b0)        begin n_fail++; $display("FAIL basic_timeout got %b want 0", to); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
    n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    n_tests++; if (out_data !== 32'h0000_C000) begin n_fail++; $display("FAIL basic_data got %h want 0000c000", out_data); end
    n_tests++; if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
    finish_job();
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic_idle busy got %b want 0", busy); end
  endtask

  task automatic test_saturate();
    logic [31:0] t[$];
    logic [31:0] v;
    bit to;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      t = '{v, v, v};
      begin_job(3);
      feed(t, 0, to);
      n_tests++; if (out_valid !== 1'b1 || to) begin n_fail++; $display("FAIL sat_valid[%0d] got %b want 1", k, out_valid); end
      n_tests++; if (out_data !== v) begin n_fail++; $display("FAIL sat_data[%0d] got %h want %h", k, out_data, v); end
      n_tests++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf[%0d] got %b want 1", k, out_ovf); end
      finish_job();
    end
  endtask

  task automatic test_zero_cancel();
    logic [31:0] t[$];
    bit to;
    t = '{32'h0001_0000, 32'h8001_0000};
    begin_job(2);
    feed(t, 0, to);
    n_tests++; if (out_valid !== 1'b1 || to) begin n_fail++; $display("FAIL zero_valid got %b want 1", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL zero_data got %h want 00000000", out_data); end
    n_tests++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL zero_ovf got %b want 0", out_ovf); end
    finish_job();
  endtask

  task automatic test_len0();
    begin_job(0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL len0_valid got %b want 1", out_valid); end
    n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL len0_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_data !== 32'h0 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL len0_result got %h/%b want 0/0", out_data, out_ovf); end
    finish_job();
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL len0_idle busy/in_ready got %b/%b want 0/0", busy, in_ready); end
  endtask

  task automatic test_hold_gaps();
    logic [31:0] t[$];
    logic [32:0] exp;
    bit to;
    t = '{};
    for (int i = 0; i < 4; i++) t.push_back(rand_term());
    exp = model(t);
    begin_job(4);
    feed(t, 40, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL hold_timeout got %b want 0", to); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp[31:0] || out_ovf !== exp[32]) begin
        n_fail++;
        $display("FAIL hold_stable[%0d] got v=%b d=%h o=%b want v=1 d=%h o=%b", k, out_valid, out_data, out_ovf, exp[31:0], exp[32]);
      end
      start = (k == 2);
      len   = LEN_W'(1);
      @(negedge clk);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_handoff_start busy got %b want 0", busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_idle busy/out_valid got %b/%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] t[$];
    logic [31:0] t2[$];
    logic [32:0] exp;
    bit to;
    t = '{rand_term(), rand_term()};
    begin_job(4);
    feed(t, 0, to);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_ovf !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs got busy=%b rdy=%b v=%b o=%b d=%h want all 0", busy, in_ready, out_valid, out_ovf, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t2 = '{rand_term(), rand_term(), rand_term()};
    exp = model(t2);
    begin_job(3);
    feed(t2, 20, to);
    n_tests++; if (out_valid !== 1'b1 || to) begin n_fail++; $display("FAIL midreset_valid got %b want 1", out_valid); end
    n_tests++;
    if (out_data !== exp[31:0] || out_ovf !== exp[32]) begin
      n_fail++;
      $display("FAIL midreset_result got %h/%b want %h/%b", out_data, out_ovf, exp[31:0], exp[32]);
    end
    finish_job();
  endtask

  task automatic test_random();
    logic [31:0] t[$];
    logic [32:0] exp;
    int l;
    bit to;
    for (int j = 0; j < 20; j++) begin
      l = $urandom_range(1, 6);
      t = '{};
      for (int i = 0; i < l; i++) t.push_back(rand_term());
      exp = model(t);
      begin_job(l);
      feed(t, 25, to);
      n_tests++;
      if (to || out_valid !== 1'b1 || out_data !== exp[31:0] || out_ovf !== exp[32]) begin
        n_fail++;
        $display("FAIL random_job[%0d] len=%0d got v=%b d=%h o=%b want v=1 d=%h o=%b", j, l, out_valid, out_data, out_ovf, exp[31:0], exp[32]);
      end
      finish_job();
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL random_idle busy got %b want 0", busy); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_saturate();
    test_zero_cancel();
    test_len0();
    test_hold_gaps();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
